// File: rtl/serial_tx_spi.sv
// serial_tx_spi: SPI-style serial transmitter running on a single clock.
// The serial clock is a registered output paced by a half-period tick
// counter. Supports CPOL/CPHA modes, NUM_CS chip selects, setup/hold
// framing and multi-word bursts under one chip select.
//
// Ports:
//   in_clk            main clock
//   in_rstn           asynchronous active-low reset
//   in_enable         start a transfer (Idle) or continue a burst
//   in_parallel       word to send
//   in_cs_sel         target slave index (>= NUM_CS selects no line)
//   out_ready         high only in Idle
//   out_next_word     one-cycle pulse on the last leading edge of a word
//   out_word_finished one-cycle pulse on the last trailing edge of a word
//   out_clk           serial clock
//   out_cs            chip selects
//   out_serial        serial data
module serial_tx_spi #(
  parameter int unsigned MAIN_CLK_HZ          = 50_000_000,
  parameter int unsigned SERIAL_CLK_HZ        = 10_000,
  parameter int unsigned BITS                 = 8,
  parameter bit          LOWBIT_FIRST         = 1'b1,
  parameter bit          CPOL                 = 1'b0,
  parameter bit          CPHA                 = 1'b0,
  parameter int unsigned NUM_CS               = 1,
  parameter bit          CS_ACTIVE            = 1'b0,
  parameter bit          SERIAL_DATA_INACTIVE = 1'b1,
  localparam int unsigned SEL_W               = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              in_clk,
  input  logic              in_rstn,
  input  logic              in_enable,
  input  logic [BITS-1:0]   in_parallel,
  input  logic [SEL_W-1:0]  in_cs_sel,
  output logic              out_ready,
  output logic              out_next_word,
  output logic              out_word_finished,
  output logic              out_clk,
  output logic [NUM_CS-1:0] out_cs,
  output logic              out_serial
);

  localparam int unsigned DIV    = MAIN_CLK_HZ / (2 * SERIAL_CLK_HZ);
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * BITS);
  localparam int unsigned IDX_W  = $clog2(BITS);

  // Elaboration-time parameter sanity checks
  if (DIV < 1) begin : g_div_chk
    $error("serial_tx_spi: MAIN_CLK_HZ/(2*SERIAL_CLK_HZ) must be >= 1");
  end
  if (BITS < 2) begin : g_bits_chk
    $error("serial_tx_spi: BITS must be >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BITS-1:0]     data_q, data_d;
  logic                clk_q, clk_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;
  logic                ser_q, ser_d;
  logic                ready_q, ready_d;
  logic                nw_q, nw_d;
  logic                wf_q, wf_d;

  logic                tick_c;
  logic                leading_c;
  logic                last_lead_c;
  logic                last_trail_c;

  // Bit at shift position i, honouring the configured bit order
  function automatic logic pick_bit(input logic [BITS-1:0] w,
                                    input logic [IDX_W-1:0] i);
    logic [BITS-1:0] r;
    for (int unsigned k = 0; k < BITS; k++) begin
      r[k] = LOWBIT_FIRST ? w[k] : w[BITS-1-k];
    end
    return r[i];
  endfunction

  // One-hot-active chip-select pattern; out-of-range index selects nothing
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      v[i] = (32'(sel) == i) ? CS_ACTIVE : ~CS_ACTIVE;
    end
    return v;
  endfunction

  assign tick_c       = (cnt_q == CNT_W'(DIV - 1));
  // edge_q holds the number of ticks already taken in this word, so an
  // even value means the upcoming tick is a leading edge
  assign leading_c    = ~edge_q[0];
  assign last_lead_c  = (edge_q == EDGE_W'(2 * BITS - 2));
  assign last_trail_c = (edge_q == EDGE_W'(2 * BITS - 1));

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    idx_d   = idx_q;
    data_d  = data_q;
    clk_d   = clk_q;
    cs_d    = cs_q;
    ser_d   = ser_q;
    ready_d = ready_q;
    nw_d    = 1'b0;
    wf_d    = 1'b0;

    if (state_q != ST_IDLE) begin
      cnt_d = tick_c ? '0 : CNT_W'(cnt_q + CNT_W'(1));
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (in_enable) begin
          state_d = ST_SETUP;
          data_d  = in_parallel;
          idx_d   = '0;
          edge_d  = '0;
          ready_d = 1'b0;
          clk_d   = CPOL;
          cs_d    = cs_decode(in_cs_sel);
          ser_d   = pick_bit(in_parallel, '0);
        end
      end

      ST_SETUP: begin
        if (tick_c) begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick_c) begin
          clk_d  = ~clk_q;
          edge_d = EDGE_W'(edge_q + EDGE_W'(1));
          if (last_lead_c) begin
            nw_d = 1'b1;
          end
          // Mid-word bit advance: trailing edges for CPHA=0, leading for CPHA=1
          if ((!CPHA && !leading_c && !last_trail_c) ||
              (CPHA && leading_c && (edge_q != '0))) begin
            idx_d = IDX_W'(idx_q + IDX_W'(1));
            ser_d = pick_bit(data_q, IDX_W'(idx_q + IDX_W'(1)));
          end
          if (last_trail_c) begin
            wf_d   = 1'b1;
            edge_d = '0;
            if (in_enable) begin
              // Burst: next word starts on this edge, no clock gap
              data_d = in_parallel;
              idx_d  = '0;
              ser_d  = pick_bit(in_parallel, '0);
            end else begin
              state_d = ST_HOLD;
            end
          end
        end
      end

      ST_HOLD: begin
        if (tick_c) begin
          state_d = ST_IDLE;
          cs_d    = {NUM_CS{~CS_ACTIVE}};
          ser_d   = SERIAL_DATA_INACTIVE;
          ready_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      clk_q   <= CPOL;
      cs_q    <= {NUM_CS{~CS_ACTIVE}};
      ser_q   <= SERIAL_DATA_INACTIVE;
      ready_q <= 1'b1;
      nw_q    <= 1'b0;
      wf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      clk_q   <= clk_d;
      cs_q    <= cs_d;
      ser_q   <= ser_d;
      ready_q <= ready_d;
      nw_q    <= nw_d;
      wf_q    <= wf_d;
    end
  end

  assign out_ready         = ready_q;
  assign out_next_word     = nw_q;
  assign out_word_finished = wf_q;
  assign out_clk           = clk_q;
  assign out_cs            = cs_q;
  assign out_serial        = ser_q;

endmodule
